// File: rtl/aging_report_tx.sv
// Buffers end-of-window aging codes in a small FIFO, tags each with a 4-bit
// sequence number and sends it off-chip as a two-byte 8N1 UART frame.
module aging_report_tx #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  input  logic [DATA_W-1:0]             aging_signal,
  output logic                          txd,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [3:0]    seq;
  logic [3:0]    code_ext;
  logic [7:0]    payload;
  logic [7:0]    cur_byte;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          sel_payload;
  logic          full, empty, push, pop, bit_end;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = (state == IDLE) && !empty;
  assign push       = sample_valid && (!full || pop);
  assign fifo_level = wr_ptr - rd_ptr;
  assign code_ext   = 4'(aging_signal);
  assign cur_byte   = sel_payload ? payload : HEADER;
  assign bit_end    = (baud_cnt == CW'(CLK_DIV - 1));

  // NOTE: sample storage has no reset; the pointers alone define what is valid,
  // so flushing on reset only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {seq, code_ext};
  end

  // NOTE: every clocked block uses non-blocking assignments so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      // seq advances on dropped samples too, so the host can see gaps.
      if (sample_valid) seq <= seq + 4'd1;
      if (push)         wr_ptr <= wr_ptr + 1'b1;
      if (pop)          rd_ptr <= rd_ptr + 1'b1;
      if (sample_valid && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      txd         <= 1'b1;
      busy        <= 1'b0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      sel_payload <= 1'b0;
      payload     <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        payload     <= mem[rd_ptr[AW-1:0]];
        sel_payload <= 1'b0;
        state       <= START;
        txd         <= 1'b0;
        busy        <= 1'b1;
        baud_cnt    <= '0;
      end
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      unique case (state)
        START: begin
          state   <= DATA;
          bit_idx <= '0;
          txd     <= cur_byte[0];
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            txd   <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 3'd1;
            txd     <= cur_byte[bit_idx + 3'd1];
          end
        end
        STOP: begin
          if (!sel_payload) begin
            sel_payload <= 1'b1;
            state       <= START;
            txd         <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aging_report_tx.sv
// Scoreboard bench for aging_report_tx: expected line bytes are queued at
// stimulus time and a UART receiver process decodes txd and compares.
module tb_aging_report_tx;

  localparam int         CLK_DIV    = 4;
  localparam int         FIFO_DEPTH = 4;
  localparam int         DATA_W     = 4;
  localparam logic [7:0] HEADER     = 8'hA5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] aging_signal = '0;
  logic              txd, busy, overflow;
  logic [2:0]        fifo_level;

  int         n_vec  = 0;
  int         n_fail = 0;
  int         epoch  = 0;
  logic [7:0] exp_q[$];

  aging_report_tx #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .HEADER(HEADER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .aging_signal(aging_signal), .txd(txd), .busy(busy),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [7:0] pl);
    exp_q.push_back(HEADER);
    exp_q.push_back(pl);
  endtask

  // Strobe one sample; it is captured at the second posedge.
  task automatic strobe(input logic [3:0] a, input logic [7:0] pl, input bit accepted);
    @(posedge clk); #1;
    sample_valid = 1'b1;
    aging_signal = a;
    if (accepted) expect_frame(pl);
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    epoch++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((busy || fifo_level != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 32'(t < 3000), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_idle_gap();
    int t = 0;
    int g = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    while (!busy && g < 10) begin @(negedge clk); g++; end
    check("idle_gap", g, 1);
  endtask

  // UART receiver: first low negedge is the start bit, then mid-bit sampling.
  initial begin : monitor
    int         ep;
    logic [7:0] rx;
    logic       stop_bit;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        ep = epoch;
        repeat (CLK_DIV + CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx[i] = txd;
          if (i < 7) repeat (CLK_DIV) @(negedge clk);
        end
        repeat (CLK_DIV) @(negedge clk);
        stop_bit = txd;
        if (ep == epoch) begin
          check("stop_bit", 32'(stop_bit), 1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rx_byte: got 0x%0h, expected no byte", rx);
          end else begin
            check("rx_byte", 32'(rx), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int n;

    // Single sample: reset state, frame A5/03, busy for 20 bit times.
    do_reset();
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_level", 32'(fifo_level), 0);
    strobe(4'h3, 8'h03, 1'b1);
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    n = 0;
    while (busy && n < 200) begin n++; @(negedge clk); end
    check("busy_cycles", n, 80);
    check("level_after_single", 32'(fifo_level), 0);
    wait_drain();

    // Back-to-back samples: three frames with a single IDLE cycle between.
    do_reset();
    strobe(4'h1, 8'h01, 1'b1);
    strobe(4'h2, 8'h12, 1'b1);
    strobe(4'h3, 8'h23, 1'b1);
    check_idle_gap();
    check_idle_gap();
    wait_drain();
    check("b2b_overflow", 32'(overflow), 0);

    // Overflow: 1 popped, 4 buffered, 6th dropped; seq 5 is skipped on the line.
    do_reset();
    strobe(4'h0, 8'h00, 1'b1);
    strobe(4'h1, 8'h11, 1'b1);
    strobe(4'h2, 8'h22, 1'b1);
    strobe(4'h3, 8'h33, 1'b1);
    strobe(4'h4, 8'h44, 1'b1);
    check("ovf_before_drop", 32'(overflow), 0);
    strobe(4'h5, 8'h55, 1'b0);
    @(negedge clk);
    check("ovf_level_full", 32'(fifo_level), 4);
    check("ovf_set", 32'(overflow), 1);
    wait_drain();
    check("ovf_sticky", 32'(overflow), 1);
    strobe(4'h9, 8'h69, 1'b1);
    wait_drain();

    // Push in the same cycle IDLE pops while the FIFO is full.
    do_reset();
    strobe(4'h8, 8'h08, 1'b1);
    strobe(4'h9, 8'h19, 1'b1);
    strobe(4'hA, 8'h2A, 1'b1);
    strobe(4'hB, 8'h3B, 1'b1);
    strobe(4'hC, 8'h4C, 1'b1);
    check("full_level", 32'(fifo_level), 4);
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    check("full_idle_reached", 32'(busy), 0);
    sample_valid = 1'b1;
    aging_signal = 4'hD;
    expect_frame(8'h5D);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("pushpop_level", 32'(fifo_level), 4);
    check("pushpop_overflow", 32'(overflow), 0);
    check("pushpop_busy", 32'(busy), 1);
    wait_drain();

    // Reset during payload bit 3 (payload 0x05, bit 3 is 0).
    do_reset();
    strobe(4'h5, 8'h05, 1'b1);
    strobe(4'h6, 8'h16, 1'b1);
    repeat (57) @(negedge clk);
    check("midframe_bit3", 32'(txd), 0);
    check("midframe_level", 32'(fifo_level), 1);
    exp_q.delete();
    epoch++;
    rst_n = 1'b0;
    #1;
    check("async_txd", 32'(txd), 1);
    check("async_busy", 32'(busy), 0);
    check("async_level", 32'(fifo_level), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    strobe(4'h7, 8'h07, 1'b1);
    wait_drain();

    // Sequence wrap: the 17th sample carries seq 0 again.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      strobe(4'(i), {4'(i), 4'(i)}, 1'b1);
      wait_drain();
    end

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
